// File: rtl/burst_stream_source_pkg.sv
// Shared types and data-pattern helper for the burst stream source.
package burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MODE_ZERO  = 2'd0,
      MODE_INDEX = 2'd1,
      MODE_INV   = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_t;

   // Payload for beat index idx; callers truncate the result to their data width.
   // The reserved mode deliberately falls through to the index pattern.
   function automatic logic [31:0] pattern(input mode_t mode, input logic [31:0] idx);
      case (mode)
         MODE_ZERO: return '0;
         MODE_INV:  return ~idx;
         default:   return idx;
      endcase
   endfunction

endpackage

// File: rtl/burst_stream_source_if.sv
// Valid/ready beat stream between a source (master) and a sink (slave).
interface burst_stream_source_if #(
   parameter int DATA_W = 8
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/burst_stream_source.sv
// Sends a bounded burst of patterned beats on a start command and reports
// busy while sending and a one-cycle done pulse when the burst finishes.
module burst_stream_source
   import burst_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     limit,
   input  logic [1:0]           mode,
   burst_stream_source_if.master src,
   output logic                 busy,
   output logic                 done
);

   state_t              r_state;
   mode_t               r_mode;
   logic [LEN_W-1:0]    r_lim;
   logic [LEN_W-1:0]    r_cnt;
   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   logic                r_last;
   logic                r_busy;
   logic                r_done;

   logic                w_hs;
   logic [LEN_W-1:0]    w_last_idx;
   logic [LEN_W-1:0]    w_cnt_nxt;

   assign w_hs       = r_valid && src.out_ready;
   assign w_last_idx = r_lim - LEN_W'(1);
   assign w_cnt_nxt  = r_cnt + LEN_W'(1);

   assign src.out_valid = r_valid;
   assign src.out_data  = r_data;
   assign src.out_last  = r_last;
   assign busy          = r_busy;
   assign done          = r_done;

   // FSM with registered outputs; the payload for the next beat is computed
   // from the incremented counter so data and last change only on a handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_ZERO;
         r_lim   <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_lim  <= limit;
                  r_mode <= mode_t'(mode);
                  r_cnt  <= '0;
                  if (limit != '0) begin
                     r_state <= ST_ACTIVE;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                     r_data  <= DATA_W'(pattern(mode_t'(mode), '0));
                     r_last  <= (limit == LEN_W'(1));
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (w_hs) begin
                  if (r_cnt == w_last_idx) begin
                     r_state <= ST_DONE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_last  <= 1'b0;
                     r_data  <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt  <= w_cnt_nxt;
                     r_data <= DATA_W'(pattern(r_mode, 32'(w_cnt_nxt)));
                     r_last <= (w_cnt_nxt == w_last_idx);
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_last  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/burst_stream_source.md
Name: burst_stream_source

Overview:
- Transmit-side counterpart of the team's valid/ready consumer. The consumer gates its IDLE/ACTIVE state on enable && valid && ready.
- On a start command, this block sends a bounded burst of data beats, one per accepted handshake. It stops when its counter reaches the programmed limit.
- It sits in front of any stream sink in the test fabric. It reports busy/done to a controlling sequencer.

Parameters:
DATA_W, 8, width of out_data
LEN_W, 4, width of limit and internal beat counter (max burst = 2**LEN_W - 1 beats)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
limit  input  LEN_W  number of beats in burst, sampled with start
mode  input  2  data pattern select, sampled with start
out_valid  output  1  beat available
out_ready  input  1  sink accepts beat
out_data  output  DATA_W  beat payload
out_last  output  1  marks final beat of burst, qualified by out_valid
busy  output  1  high in ACTIVE
done  output  1  one-cycle pulse after burst completes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on any edge with rst=1 the state goes to IDLE. out_valid, out_data, out_last, busy, done and the internal counter all clear to 0. rst overrides start and any in-flight handshake. A burst interrupted by reset is abandoned, with no done pulse.
- States:
  - IDLE: start=1 captures limit into lim_q and mode into mode_q, and sets counter=0. If limit!=0 go to ACTIVE. If limit==0 go to DONE with no beats.
  - ACTIVE: out_valid=1 and busy=1. A handshake is out_valid && out_ready. On a handshake with counter==lim_q-1, go to DONE. On any other handshake, counter increments.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start at edge t makes out_valid=1 after edge t, i.e. the first beat is visible in cycle t+1. If out_ready is held high, beats go out back-to-back, one per cycle. done is asserted in the cycle after the final handshake.
- Stability: while out_valid && !out_ready, out_data and out_last hold constant. out_valid never drops without a handshake.
- Data pattern, computed from counter zero-extended to DATA_W (truncated if LEN_W>DATA_W):
  - mode 0: all zeros.
  - mode 1: counter.
  - mode 2: bitwise ~counter.
  - mode 3: reserved, behaves as mode 1.
- out_last = (counter == lim_q-1) while in ACTIVE, otherwise 0.
- start while busy or in DONE: ignored. limit and mode changes after capture: ignored.
- Counter never wraps. Its maximum value is lim_q-1, and lim_q is at most 2**LEN_W-1.
- out_ready while out_valid=0: no effect.

Decomposition:
- Shared package burst_pkg:
  - state encoding ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_DONE=2'd2.
  - mode constants MODE_ZERO=0, MODE_INDEX=1, MODE_INV=2.
  - pattern function pattern(mode, idx).
- Single module. No sub-module needed: FSM, counter and pattern mux fit in roughly 150 lines.

Test Plan:
1. Reset then start, limit=4, mode=1, out_ready=1 held -> out_data 0,1,2,3 on four consecutive cycles; out_last only on the 3; done pulse one cycle after; busy low thereafter.
2. start, limit=3, mode=2, DATA_W=8, out_ready toggled 1,0,0,1,1 -> beats 8'hFF, 8'hFE, 8'hFD; each beat held stable through the ready=0 cycles; exactly 3 handshakes.
3. start, limit=0 -> out_valid never asserts; done pulses in the cycle after start; state returns to IDLE.
4. start, limit=5, then start re-pulsed with limit=2 during ACTIVE -> original 5-beat burst completes unchanged; second start is ignored.
5. start, limit=6, rst=1 asserted after the 2nd handshake -> next cycle all outputs 0, no done pulse; a new start, limit=1, mode=0 yields a single beat 8'h00 with out_last=1.
6. start, limit=15 (maximum), mode=3, out_ready=1 -> 15 beats 0..14, out_last on 14, no counter wrap, done after.
